// File: rtl/tex_dcr_file_pkg.sv
// Texture DCR types and constants shared by the DCR register file and its decoder.
// Holds the per-stage record (tex_dcrs_t), the request CSR view (tex_csrs_t),
// the response bundle (tex_dcr_rsp_t), field widths, DCR addresses and the
// bit positions of the decoder's one-hot field select.
package tex_dcr_file_pkg;

    localparam int TEX_STAGE_BITS  = 2;
    localparam int TEX_ADDR_BITS   = 32;
    localparam int TEX_LOD_BITS    = 4;
    localparam int TEX_LOD_MAX     = 11;
    localparam int TEX_WRAP_BITS   = 2;
    localparam int TEX_FORMAT_BITS = 3;
    localparam int TEX_FILTER_BITS = 2;
    localparam int TEX_MIPOFF_BITS = 20;
    localparam int TEX_TAG_WIDTH   = 8;
    localparam int DCR_ADDR_BITS   = 8;

    localparam logic [DCR_ADDR_BITS-1:0] DCR_TEX_STAGE  = 8'h10;
    localparam logic [DCR_ADDR_BITS-1:0] DCR_TEX_ADDR   = 8'h11;
    localparam logic [DCR_ADDR_BITS-1:0] DCR_TEX_LOGDIM = 8'h12;
    localparam logic [DCR_ADDR_BITS-1:0] DCR_TEX_WRAP   = 8'h13;
    localparam logic [DCR_ADDR_BITS-1:0] DCR_TEX_FORMAT = 8'h14;
    localparam logic [DCR_ADDR_BITS-1:0] DCR_TEX_FILTER = 8'h15;
    localparam logic [DCR_ADDR_BITS-1:0] DCR_TEX_MIPOFF = 8'h16;

    // One-hot field select bit positions; mipoff levels occupy SEL_MIPOFF..NUM_SEL-1.
    localparam int SEL_STAGE  = 0;
    localparam int SEL_ADDR   = 1;
    localparam int SEL_LOGDIM = 2;
    localparam int SEL_WRAP   = 3;
    localparam int SEL_FORMAT = 4;
    localparam int SEL_FILTER = 5;
    localparam int SEL_MIPOFF = 6;
    localparam int NUM_SEL    = SEL_MIPOFF + TEX_LOD_MAX + 1;

    typedef struct packed {
        logic [TEX_LOD_MAX:0][TEX_MIPOFF_BITS-1:0] mipoff;
        logic [1:0][TEX_LOD_BITS-1:0]              logdims;
        logic [1:0][TEX_WRAP_BITS-1:0]             wraps;
        logic [TEX_ADDR_BITS-1:0]                  baddr;
        logic [TEX_FORMAT_BITS-1:0]                format;
        logic [TEX_FILTER_BITS-1:0]                filter;
    } tex_dcrs_t;

    typedef struct packed {
        logic [TEX_STAGE_BITS-1:0] stage;
    } tex_csrs_t;

    typedef struct packed {
        logic [TEX_TAG_WIDTH-1:0] tag;
        logic                     err;
        tex_dcrs_t                dcrs;
    } tex_dcr_rsp_t;

endpackage

// File: rtl/tex_dcr_file_decode.sv
// Combinational DCR write decoder.
// Ports:
//   addr   - DCR address
//   data   - DCR write data
//   sel    - one-hot field select (bit layout from SEL_* in the package)
//   stage  - stage selector value carried by a DCR_TEX_STAGE write
//   fields - every record field extracted from data; sel decides which one lands
module tex_dcr_file_decode
    import tex_dcr_file_pkg::*;
(
    input  logic [DCR_ADDR_BITS-1:0]  addr,
    input  logic [31:0]               data,
    output logic [NUM_SEL-1:0]        sel,
    output logic [TEX_STAGE_BITS-1:0] stage,
    output tex_dcrs_t                 fields
);

    always_comb begin
        sel             = '0;
        sel[SEL_STAGE]  = (addr == DCR_TEX_STAGE);
        sel[SEL_ADDR]   = (addr == DCR_TEX_ADDR);
        sel[SEL_LOGDIM] = (addr == DCR_TEX_LOGDIM);
        sel[SEL_WRAP]   = (addr == DCR_TEX_WRAP);
        sel[SEL_FORMAT] = (addr == DCR_TEX_FORMAT);
        sel[SEL_FILTER] = (addr == DCR_TEX_FILTER);
        for (int k = 0; k <= TEX_LOD_MAX; k++) begin
            sel[SEL_MIPOFF + k] = (addr == DCR_TEX_MIPOFF + DCR_ADDR_BITS'(k));
        end
    end

    always_comb begin
        stage              = data[TEX_STAGE_BITS-1:0];
        fields             = '0;
        fields.baddr       = data[TEX_ADDR_BITS-1:0];
        fields.logdims[0]  = data[TEX_LOD_BITS-1:0];
        fields.logdims[1]  = data[16 +: TEX_LOD_BITS];
        fields.wraps[0]    = data[TEX_WRAP_BITS-1:0];
        fields.wraps[1]    = data[16 +: TEX_WRAP_BITS];
        fields.format      = data[TEX_FORMAT_BITS-1:0];
        fields.filter      = data[TEX_FILTER_BITS-1:0];
        for (int k = 0; k <= TEX_LOD_MAX; k++) begin
            fields.mipoff[k] = data[TEX_MIPOFF_BITS-1:0];
        end
    end

endmodule

// File: rtl/tex_dcr_file.sv
// Per-stage texture DCR register file feeding the sampler pipeline.
// Ports:
//   clk, reset_n                 - clock, async active-low reset
//   dcr_wr_valid/addr/data       - host DCR write (single cycle, no backpressure)
//   req_valid/stage/tag, req_ready  - lookup request handshake
//   rsp_valid/dcrs/tag/err, rsp_ready - registered lookup response, 1-cycle latency
//   cfg_err                      - sticky: a field write hit an out-of-range stage
module tex_dcr_file
    import tex_dcr_file_pkg::*;
#(
    parameter int NUM_STAGES = 2,
    parameter int TAG_WIDTH  = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      dcr_wr_valid,
    input  logic [DCR_ADDR_BITS-1:0]  dcr_wr_addr,
    input  logic [31:0]               dcr_wr_data,
    input  logic                      req_valid,
    input  logic [TEX_STAGE_BITS-1:0] req_stage,
    input  logic [TAG_WIDTH-1:0]      req_tag,
    output logic                      req_ready,
    output logic                      rsp_valid,
    output tex_dcrs_t                 rsp_dcrs,
    output logic [TAG_WIDTH-1:0]      rsp_tag,
    output logic                      rsp_err,
    input  logic                      rsp_ready,
    output logic                      cfg_err
);

    localparam logic [TEX_STAGE_BITS:0] NUM_STAGES_W = NUM_STAGES[TEX_STAGE_BITS:0];

    tex_dcrs_t                 records [NUM_STAGES];
    logic [TEX_STAGE_BITS-1:0] selector;

    logic [NUM_SEL-1:0]        dec_sel;
    logic [TEX_STAGE_BITS-1:0] dec_stage;
    tex_dcrs_t                 dec_fields;

    logic      field_hit;
    logic      sel_in_range;
    logic      req_fire;
    logic      req_err;
    tex_dcrs_t lookup;

    tex_dcr_file_decode u_decode (
        .addr   (dcr_wr_addr),
        .data   (dcr_wr_data),
        .sel    (dec_sel),
        .stage  (dec_stage),
        .fields (dec_fields)
    );

    assign field_hit    = |dec_sel[NUM_SEL-1:SEL_ADDR];
    assign sel_in_range = ({1'b0, selector} < NUM_STAGES_W);
    assign req_ready    = !rsp_valid || rsp_ready;
    assign req_fire     = req_valid && req_ready;
    assign req_err      = !({1'b0, req_stage} < NUM_STAGES_W);

    // An out-of-range stage matches no entry, so the lookup falls back to all-zero.
    always_comb begin
        lookup = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (req_stage == TEX_STAGE_BITS'(i)) lookup = records[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            selector <= '0;
            cfg_err  <= 1'b0;
        end else if (dcr_wr_valid) begin
            if (dec_sel[SEL_STAGE]) selector <= dec_stage;
            else if (field_hit && !sel_in_range) cfg_err <= 1'b1;
        end
    end

    // Records are read with their pre-edge value, so a same-cycle write and
    // lookup of one stage returns the old contents.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_STAGES; i++) records[i] <= '0;
        end else if (dcr_wr_valid && field_hit && sel_in_range) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                if (selector == TEX_STAGE_BITS'(i)) begin
                    if (dec_sel[SEL_ADDR])   records[i].baddr   <= dec_fields.baddr;
                    if (dec_sel[SEL_LOGDIM]) records[i].logdims <= dec_fields.logdims;
                    if (dec_sel[SEL_WRAP])   records[i].wraps   <= dec_fields.wraps;
                    if (dec_sel[SEL_FORMAT]) records[i].format  <= dec_fields.format;
                    if (dec_sel[SEL_FILTER]) records[i].filter  <= dec_fields.filter;
                    for (int k = 0; k <= TEX_LOD_MAX; k++) begin
                        if (dec_sel[SEL_MIPOFF + k]) records[i].mipoff[k] <= dec_fields.mipoff[k];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid <= 1'b0;
            rsp_dcrs  <= '0;
            rsp_tag   <= '0;
            rsp_err   <= 1'b0;
        end else if (req_fire) begin
            rsp_valid <= 1'b1;
            rsp_dcrs  <= lookup;
            rsp_tag   <= req_tag;
            rsp_err   <= req_err;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tex_dcr_file.sv
module tb_tex_dcr_file;
    import tex_dcr_file_pkg::*;

    localparam int NS = 2;
    localparam int TW = 8;

    logic                      clk;
    logic                      reset_n;
    logic                      dcr_wr_valid;
    logic [DCR_ADDR_BITS-1:0]  dcr_wr_addr;
    logic [31:0]               dcr_wr_data;
    logic                      req_valid;
    logic [TEX_STAGE_BITS-1:0] req_stage;
    logic [TW-1:0]             req_tag;
    logic                      req_ready;
    logic                      rsp_valid;
    tex_dcrs_t                 rsp_dcrs;
    logic [TW-1:0]             rsp_tag;
    logic                      rsp_err;
    logic                      rsp_ready;
    logic                      cfg_err;

    tex_dcr_file #(.NUM_STAGES(NS), .TAG_WIDTH(TW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .dcr_wr_valid (dcr_wr_valid),
        .dcr_wr_addr  (dcr_wr_addr),
        .dcr_wr_data  (dcr_wr_data),
        .req_valid    (req_valid),
        .req_stage    (req_stage),
        .req_tag      (req_tag),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_dcrs     (rsp_dcrs),
        .rsp_tag      (rsp_tag),
        .rsp_err      (rsp_err),
        .rsp_ready    (rsp_ready),
        .cfg_err      (cfg_err)
    );

    typedef struct {
        logic [TW-1:0] tag;
        logic          err;
        tex_dcrs_t     dcrs;
    } exp_t;

    exp_t       sb[$];
    tex_dcrs_t  model [4];
    logic [1:0] m_sel;
    logic       m_cfg;
    int         checks = 0;
    int         errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [319:0] obs, input logic [319:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 4; s++) model[s] = '0;
        m_sel = '0;
        m_cfg = 1'b0;
    endtask

    task automatic apply_write(input logic [7:0] a, input logic [31:0] d);
        int  idx;
        logic is_field;
        is_field = (a >= DCR_TEX_ADDR && a <= DCR_TEX_FILTER) ||
                   (a >= DCR_TEX_MIPOFF && a <= DCR_TEX_MIPOFF + 8'(TEX_LOD_MAX));
        if (a == DCR_TEX_STAGE) begin
            m_sel = d[1:0];
        end else if (is_field) begin
            if (int'(m_sel) >= NS) begin
                m_cfg = 1'b1;
            end else if (a == DCR_TEX_ADDR) begin
                model[m_sel].baddr = d;
            end else if (a == DCR_TEX_LOGDIM) begin
                model[m_sel].logdims[0] = d[3:0];
                model[m_sel].logdims[1] = d[19:16];
            end else if (a == DCR_TEX_WRAP) begin
                model[m_sel].wraps[0] = d[1:0];
                model[m_sel].wraps[1] = d[17:16];
            end else if (a == DCR_TEX_FORMAT) begin
                model[m_sel].format = d[2:0];
            end else if (a == DCR_TEX_FILTER) begin
                model[m_sel].filter = d[1:0];
            end else begin
                idx = int'(a - DCR_TEX_MIPOFF);
                model[m_sel].mipoff[idx] = d[19:0];
            end
        end
    endtask

    // One clock of stimulus: drive, check/retire the current response at the
    // falling edge, enqueue the expectation for a request accepted this cycle,
    // then apply any DCR write to the model after the rising edge.
    task automatic do_cycle(input logic wv, input logic [7:0] waddr, input logic [31:0] wdata,
                            input logic rv, input logic [1:0] rstage, input logic [TW-1:0] rtag,
                            input logic rdy, output logic acc);
        exp_t e;
        dcr_wr_valid = wv;
        dcr_wr_addr  = waddr;
        dcr_wr_data  = wdata;
        req_valid    = rv;
        req_stage    = rstage;
        req_tag      = rtag;
        rsp_ready    = rdy;
        @(negedge clk);
        chk("rsp_valid", 320'(rsp_valid), 320'(sb.size() != 0));
        chk("req_ready", 320'(req_ready), 320'(sb.size() == 0 || rdy));
        chk("cfg_err", 320'(cfg_err), 320'(m_cfg));
        if (sb.size() != 0 && rsp_valid) begin
            chk("rsp_tag", 320'(rsp_tag), 320'(sb[0].tag));
            chk("rsp_err", 320'(rsp_err), 320'(sb[0].err));
            chk("rsp_dcrs", 320'(rsp_dcrs), 320'(sb[0].dcrs));
            if (rdy) void'(sb.pop_front());
        end
        acc = rv && req_ready;
        if (acc) begin
            e.tag  = rtag;
            e.err  = (int'(rstage) >= NS);
            e.dcrs = e.err ? '0 : model[rstage];
            sb.push_back(e);
        end
        @(posedge clk);
        if (wv) apply_write(waddr, wdata);
        #1;
        dcr_wr_valid = 1'b0;
        req_valid    = 1'b0;
        rsp_ready    = 1'b1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        logic acc;
        do_cycle(1'b1, a, d, 1'b0, 2'd0, '0, 1'b1, acc);
    endtask

    task automatic rq(input logic [1:0] s, input logic [TW-1:0] t);
        logic acc;
        do_cycle(1'b0, 8'h00, 32'h0, 1'b1, s, t, 1'b1, acc);
    endtask

    task automatic idle();
        logic acc;
        do_cycle(1'b0, 8'h00, 32'h0, 1'b0, 2'd0, '0, 1'b1, acc);
    endtask

    initial begin
        logic acc;
        reset_n      = 1'b0;
        dcr_wr_valid = 1'b0;
        dcr_wr_addr  = '0;
        dcr_wr_data  = '0;
        req_valid    = 1'b0;
        req_stage    = '0;
        req_tag      = '0;
        rsp_ready    = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        chk("reset_rsp_valid", 320'(rsp_valid), 320'(1'b0));
        chk("reset_rsp_dcrs", 320'(rsp_dcrs), 320'(0));
        chk("reset_rsp_tag", 320'(rsp_tag), 320'(0));
        chk("reset_cfg_err", 320'(cfg_err), 320'(1'b0));
        chk("reset_req_ready", 320'(req_ready), 320'(1'b1));

        // Stage 0 after reset reads all zero.
        rq(2'd0, 8'h01);
        idle();

        // Program stage 1; selector write immediately followed by field writes.
        wr(DCR_TEX_STAGE, 32'h1);
        wr(DCR_TEX_ADDR, 32'h0000_1000);
        wr(DCR_TEX_LOGDIM, 32'h0008_0009);
        wr(DCR_TEX_WRAP, 32'h0002_0001);
        wr(DCR_TEX_FILTER, 32'h2);
        wr(8'hFF, 32'hFFFF_FFFF);
        wr(DCR_TEX_MIPOFF + 8'(TEX_LOD_MAX) + 8'd1, 32'hFFFF_FFFF);
        rq(2'd1, 8'h02);
        rq(2'd0, 8'h03);
        idle();

        // Program stage 0 mip offsets and base, including the top LOD level.
        wr(DCR_TEX_STAGE, 32'h0);
        wr(DCR_TEX_MIPOFF + 8'd0, 32'h0);
        wr(DCR_TEX_MIPOFF + 8'd1, 32'h400);
        wr(DCR_TEX_MIPOFF + 8'd2, 32'h500);
        wr(DCR_TEX_MIPOFF + 8'd3, 32'h540);
        wr(DCR_TEX_MIPOFF + 8'(TEX_LOD_MAX), 32'hFFF_ABCDE);
        wr(DCR_TEX_ADDR, 32'h0000_1000);

        // Backpressure: response held 3 cycles while a write lands (snapshot).
        rq(2'd0, 8'h04);
        for (int k = 0; k < 3; k++) begin
            do_cycle(k == 1, DCR_TEX_MIPOFF + 8'd4, 32'h550, 1'b1, 2'd0, 8'h05, 1'b0, acc);
        end
        do_cycle(1'b0, 8'h00, 32'h0, 1'b1, 2'd0, 8'h05, 1'b1, acc);
        idle();

        // Same-cycle write and lookup of stage 0: old base, then new base.
        do_cycle(1'b1, DCR_TEX_ADDR, 32'h0000_2000, 1'b1, 2'd0, 8'h06, 1'b1, acc);
        rq(2'd0, 8'h07);
        idle();

        // Out-of-range selector: field write dropped, sticky error.
        wr(DCR_TEX_STAGE, 32'h3);
        wr(DCR_TEX_FORMAT, 32'h5);
        rq(2'd3, 8'h08);
        rq(2'd2, 8'h09);
        rq(2'd1, 8'h0A);
        rq(2'd0, 8'h0B);
        idle();

        // Eight back-to-back requests at full throughput.
        for (int i = 0; i < 8; i++) rq(2'(i % 2), 8'h10 + 8'(i));
        idle();

        // Burst interrupted by reset: response dropped asynchronously.
        for (int i = 0; i < 4; i++) rq(2'(i % 2), 8'h20 + 8'(i));
        reset_n = 1'b0;
        #1;
        chk("async_rst_rsp_valid", 320'(rsp_valid), 320'(1'b0));
        chk("async_rst_rsp_tag", 320'(rsp_tag), 320'(0));
        chk("async_rst_cfg_err", 320'(cfg_err), 320'(1'b0));
        sb.delete();
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        rq(2'd0, 8'h30);
        rq(2'd1, 8'h31);
        // Selector is back at 0 after reset, so this format lands on stage 0.
        wr(DCR_TEX_FORMAT, 32'h5);
        rq(2'd0, 8'h32);
        rq(2'd1, 8'h33);
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tex_dcr_file.md
Name: tex_dcr_file

Overview:
- Per-stage texture DCR register file sitting directly upstream of the texture sampler pipeline.
- Absorbs host DCR writes and stores one tex_dcrs_t per texture stage.
- On each sampler request, looks up the stage named by the request's CSR stage value and returns the full tex_dcrs_t one cycle later.
- The returned record carries mipoff, logdims, wraps, baddr, format and filter, and feeds the address/format stages.

Parameters:
- NUM_STAGES, 2, number of texture stages held (1..2^TEX_STAGE_BITS).
- TAG_WIDTH, 8, width of opaque request tag carried to the response.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- dcr_wr_valid  in  1  DCR write strobe, single cycle, no backpressure.
- dcr_wr_addr  in  DCR_ADDR_BITS  DCR address.
- dcr_wr_data  in  32  DCR write data.
- req_valid  in  1  lookup request valid.
- req_stage  in  TEX_STAGE_BITS  stage index (from tex_csrs_t.stage).
- req_tag  in  TAG_WIDTH  request tag.
- req_ready  out  1  request accepted when valid&&ready.
- rsp_valid  out  1  response valid.
- rsp_dcrs  out  tex_dcrs_t  stage state.
- rsp_tag  out  TAG_WIDTH  echoed tag.
- rsp_err  out  1  request stage was out of range.
- rsp_ready  in  1  downstream ready.
- cfg_err  out  1  sticky flag: a write hit an out-of-range stage.

Behaviour:
- Reset (async assert, sync release): all stage records zero, write-stage selector 0, rsp_valid 0, rsp_dcrs/rsp_tag/rsp_err 0, cfg_err 0.
- Write decode, on clk edge when dcr_wr_valid:
  - DCR_TEX_STAGE: selector <= data[TEX_STAGE_BITS-1:0].
  - DCR_TEX_ADDR: baddr <= data[TEX_ADDR_BITS-1:0].
  - DCR_TEX_LOGDIM: logdims[0] <= data[TEX_LOD_BITS-1:0]; logdims[1] <= data[16+:TEX_LOD_BITS].
  - DCR_TEX_WRAP: wraps[0] <= data[TEX_WRAP_BITS-1:0]; wraps[1] <= data[16+:TEX_WRAP_BITS].
  - DCR_TEX_FORMAT: format <= data[TEX_FORMAT_BITS-1:0].
  - DCR_TEX_FILTER: filter <= data[TEX_FILTER_BITS-1:0].
  - DCR_TEX_MIPOFF+k, k in 0..TEX_LOD_MAX: mipoff[k] <= data[TEX_MIPOFF_BITS-1:0].
  - Any other address: ignored, no state change.
  - Field writes target the stage named by the selector. If selector >= NUM_STAGES, the write is dropped and cfg_err is set (sticky until reset).
- Lookup: req_ready = !rsp_valid || rsp_ready.
  - On accept, rsp_valid <= 1; rsp_dcrs <= record[req_stage]; rsp_tag <= req_tag; rsp_err <= (req_stage >= NUM_STAGES).
  - rsp_dcrs is all-zero when rsp_err=1.
  - Latency exactly 1 cycle; full throughput, one request per cycle under rsp_ready=1.
  - If rsp_valid && !rsp_ready: all rsp_* outputs hold stable and req_ready=0.
  - rsp_valid clears when rsp_ready is high and no new request is accepted.
- Write/read collision, same cycle and same stage: the response carries the pre-write value; the new value is visible to requests accepted on the next cycle.
- Held response: a later write does not alter a response already registered in rsp_dcrs (snapshot semantics).
- Selector update and field write in consecutive cycles: the field write uses the new selector.
- Reset asserted mid-operation: the response in flight is discarded (rsp_valid=0 immediately); all state is cleared.

Decomposition:
- The tex types package owns tex_dcrs_t, tex_csrs_t and the TEX_* width macros (already present). Add a tex_dcr_rsp_t struct {tag, err, dcrs} sized by TAG_WIDTH.
- DCR address constants stay in the shared DCR define file.
- One sub-module is natural: tex_dcr_decode. It is combinational: (addr, data) -> field-select one-hot plus extracted field values. It is reused by the top for the trace/debug path.
- The top module holds the stage array, the selector and the output register.

Test Plan:
- Reset, then request stage 0 -> rsp_valid=1 one cycle later, rsp_dcrs=0, rsp_err=0, cfg_err=0.
- Write STAGE=1, ADDR=0x00001000, LOGDIM=0x00080009, then request stage 1 and stage 0 -> stage 1 returns baddr=0x1000, logdims[0]=9, logdims[1]=8; stage 0 returns baddr=0.
- Write MIPOFF+0..+3 = 0,0x400,0x500,0x540 on stage 0; request with rsp_ready held 0 for 3 cycles -> rsp_dcrs stable, req_ready=0; on release the next queued request completes the following cycle.
- Same-cycle ADDR write 0x2000 and request on stage 0 (old 0x1000) -> response baddr=0x1000; next request -> 0x2000.
- Write STAGE=3 (NUM_STAGES=2), then FORMAT=5 -> cfg_err=1, no stage changes; request stage 3 -> rsp_err=1, rsp_dcrs=0.
- Back-to-back 8 requests with rsp_ready=1 -> 8 responses on 8 consecutive cycles, tags in order; assert reset_n low on cycle 4 -> rsp_valid drops asynchronously, all records read 0 after release.
